// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the count_sched request scheduler.
// Holds the FSM state encoding, default parameters and the round-robin pick.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_TERM    = 3;
    localparam int DEF_TIMEOUT = 15;

    // A lone request always wins; on a tie the pointer names the winner.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        case (req)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return ptr ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/count2_edge.sv
// Shared datapath for count_sched: rising-edge detector on x and a
// 2-bit saturating counter with synchronous clear and enable.
module count2_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    input  logic       hist_ld,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] cnt,
    output logic       rise
);

    logic       x_hist_q, x_hist_d;
    logic [1:0] cnt_q, cnt_d;

    assign rise = x & ~x_hist_q;
    assign cnt  = cnt_q;

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        x_hist_d = hist_ld ? x : x_hist_q;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (en && rise && (cnt_q != 2'b11)) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_hist_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            x_hist_q <= x_hist_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/count_sched.sv
// Two-requester round-robin scheduler that lends a shared x-edge counter to one requester.
// Optional watchdog abort in COUNT is enabled by defining COUNT_TIMEOUT_EN.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int TERM    = DEF_TERM,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       x,
    output logic [1:0] gnt,
    output logic [1:0] out,
    output logic       z,
    output logic [1:0] done,
    output logic       busy,
    output logic       err
);

    if (TERM < 1 || TERM > 3 || TIMEOUT < 1) begin : g_bad_param
        $error("count_sched: TERM must be 1..3 and TIMEOUT at least 1");
    end

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       ptr_q, ptr_d;
    logic       z_q, z_d;
    logic [1:0] done_q, done_d;

    logic       req_held;
    logic       hit_term;
    logic       tmo_hit;
    logic       cnt_clr;
    logic       cnt_en;
    logic       hist_ld;
    logic       rise;
    logic [1:0] cnt;

    count2_edge u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .hist_ld (hist_ld),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (cnt),
        .rise    (rise)
    );

    assign hist_ld  = (state_q == GRANT) || (state_q == COUNT);
    assign req_held = |(req & gnt_q);
    assign hit_term = rise && ((int'(cnt) + 1) == TERM);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        z_d     = 1'b0;
        done_d  = 2'b00;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_clr = 1'b1;
                if (req_held) begin
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            COUNT: begin
                // Withdrawal abandons the session: no done, counter cleared, pointer kept.
                if (!req_held) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (hit_term) begin
                        z_d     = 1'b1;
                        state_d = DONE;
                    end else if (tmo_hit) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                done_d  = gnt_q;
                ptr_d   = ~gnt_q[1];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             to_q, to_d;
    logic             err_q, err_d;

    // tmo_q numbers the current COUNT cycle since entry or the last x edge, starting at 1.
    always_comb begin
        tmo_d   = tmo_q;
        to_d    = to_q;
        err_d   = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            GRANT: begin
                tmo_d = TMO_W'(1);
                to_d  = 1'b0;
            end
            COUNT: begin
                if (rise) begin
                    tmo_d = TMO_W'(1);
                end else if (int'(tmo_q) >= TIMEOUT - 1) begin
                    tmo_hit = 1'b1;
                    to_d    = req_held;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE:    err_d = to_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            to_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign out  = cnt;
    assign z    = z_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: grant latency, counting, round-robin,
// x-level filtering, withdrawal, async reset mid-count and the optional watchdog.
module tb_count_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       x;
    logic [1:0] gnt;
    logic [1:0] out;
    logic       z;
    logic [1:0] done;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errs   = 0;

    count_sched #(.TERM(3), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .x     (x),
        .gnt   (gnt),
        .out   (out),
        .z     (z),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rise_x();
        x = 1'b1;
        tick();
        x = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  8'(gnt),  8'h0);
        check({tag, "_out"},  8'(out),  8'h0);
        check({tag, "_z"},    8'(z),    8'h0);
        check({tag, "_done"}, 8'(done), 8'h0);
        check({tag, "_busy"}, 8'(busy), 8'h0);
        check({tag, "_err"},  8'(err),  8'h0);
    endtask

    initial begin
        logic [1:0] exp_g;
        bit         err_seen;

        rst_n = 1'b0;
        req   = 2'b00;
        x     = 1'b0;
        #20;
        check_idle("rst");
        #30;
        rst_n = 1'b1;

        // Single session, requester 0, three x pulses.
        req = 2'b01;
        tick();
        check("s1_gnt", 8'(gnt), 8'h1);
        check("s1_busy", 8'(busy), 8'h1);
        tick();
        check("s1_out0", 8'(out), 8'h0);
        rise_x();
        check("s1_out1", 8'(out), 8'h1);
        check("s1_z1", 8'(z), 8'h0);
        tick();
        rise_x();
        check("s1_out2", 8'(out), 8'h2);
        tick();
        rise_x();
        check("s1_out3", 8'(out), 8'h3);
        check("s1_z", 8'(z), 8'h1);
        check("s1_gnt_dn", 8'(gnt), 8'h1);
        check("s1_done_early", 8'(done), 8'h0);
        tick();
        check("s1_done", 8'(done), 8'h1);
        check("s1_gnt_off", 8'(gnt), 8'h0);
        check("s1_z_off", 8'(z), 8'h0);
        check("s1_busy_off", 8'(busy), 8'h0);
        check("s1_out_hold", 8'(out), 8'h3);
        req = 2'b00;
        tick();
        check("s1_done_off", 8'(done), 8'h0);

        // x held high for five COUNT cycles counts once; lone req wins despite pointer=1.
        req = 2'b01;
        tick();
        check("lvl_gnt", 8'(gnt), 8'h1);
        tick();
        x = 1'b1;
        repeat (5) tick();
        check("lvl_out", 8'(out), 8'h1);
        x = 1'b0;
        tick();
        rise_x();
        check("lvl_out2", 8'(out), 8'h2);
        tick();
        rise_x();
        check("lvl_z", 8'(z), 8'h1);
        tick();
        check("lvl_done", 8'(done), 8'h1);
        req = 2'b00;
        tick();

        // Withdrawal at out=1: back to IDLE, no done, counter cleared.
        req = 2'b10;
        tick();
        check("ab_gnt", 8'(gnt), 8'h2);
        tick();
        rise_x();
        check("ab_out1", 8'(out), 8'h1);
        req = 2'b00;
        tick();
        check_idle("ab");
        tick();
        check("ab_done_late", 8'(done), 8'h0);
        // Pointer still 1 after the abort, so a tie goes to requester 1.
        req = 2'b11;
        tick();
        check("ab_ptr_tie", 8'(gnt), 8'h2);
        req = 2'b00;
        tick();
        check("ab_grant_drop", 8'(gnt), 8'h0);
        check("ab_grant_busy", 8'(busy), 8'h0);

        // Both requesting from reset: service alternates 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b11;
        for (int s = 0; s < 4; s++) begin
            exp_g = (s % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            check($sformatf("rr%0d_gnt", s), 8'(gnt), 8'(exp_g));
            tick();
            rise_x();
            tick();
            rise_x();
            tick();
            rise_x();
            check($sformatf("rr%0d_z", s), 8'(z), 8'h1);
            tick();
            check($sformatf("rr%0d_done", s), 8'(done), 8'(exp_g));
            check($sformatf("rr%0d_gnt_off", s), 8'(gnt), 8'h0);
        end
        req = 2'b00;
        tick();

        // Asynchronous reset with out=2 in COUNT.
        req = 2'b01;
        tick();
        tick();
        rise_x();
        tick();
        rise_x();
        check("ar_out2", 8'(out), 8'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("ar");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_regnt", 8'(gnt), 8'h1);
        check("ar_out_zero", 8'(out), 8'h0);
        tick();
        rise_x();
        check("ar_out1", 8'(out), 8'h1);
        req = 2'b00;
        tick();
        check("ar_abort_busy", 8'(busy), 8'h0);

        // No x edges in COUNT.
        req = 2'b01;
        tick();
        tick();
`ifdef COUNT_TIMEOUT_EN
        repeat (14) tick();
        check("to_done_early", 8'(done), 8'h0);
        check("to_err_early", 8'(err), 8'h0);
        check("to_busy", 8'(busy), 8'h1);
        tick();
        check("to_done", 8'(done), 8'h1);
        check("to_err", 8'(err), 8'h1);
        check("to_out_kept", 8'(out), 8'h0);
        req = 2'b00;
        tick();
        check("to_err_off", 8'(err), 8'h0);
`else
        err_seen = 1'b0;
        repeat (20) begin
            tick();
            if (err) err_seen = 1'b1;
        end
        check("nto_err", 8'(err_seen), 8'h0);
        check("nto_busy", 8'(busy), 8'h1);
        check("nto_done", 8'(done), 8'h0);
        req = 2'b00;
        tick();
        check("nto_idle", 8'(busy), 8'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
